// File: rtl/hb_decim_tdm.sv
// Halfband decimate-by-2 FIR sharing one multiplier across NUM_CH interleaved channels, with
// runtime-loadable pair coefficients, bypass, round-half-up, saturation and valid/ready handshakes.
module hb_decim_tdm #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned COEF_FRAC = 15,
  parameter int unsigned NUM_TAPS  = 27,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ACC_W     = 40,
  localparam int unsigned K        = (NUM_TAPS + 1) / 4,
  localparam int unsigned CA_W     = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bypass,
  input  logic              coef_we,
  input  logic [CA_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]   s_chan,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_chan,
  output logic              sat_flag,
  input  logic              clear_sat
);

  localparam int unsigned FILL_W = $clog2(NUM_TAPS + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_TAPS);
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam int unsigned CENTER = (NUM_TAPS - 1) / 2;

  // Default pair coefficients h[2k], k=0 in the low slice; entries beyond the table reset to 0.
  localparam logic [7*COEF_W-1:0] CoefDef7 = {COEF_W'(10165), COEF_W'(-2753), COEF_W'(1078),
                                              COEF_W'(-394), COEF_W'(117), COEF_W'(-25),
                                              COEF_W'(3)};
  localparam logic [K-1:0][COEF_W-1:0] CoefRst = (K * COEF_W)'(CoefDef7);

  typedef enum logic [1:0] {StIdle, StMac, StCenter, StRound} state_e;

  state_e                                              state_q, state_d;
  logic [NUM_CH-1:0][NUM_TAPS-1:0][DATA_W-1:0]         buf_q, buf_d;
  logic [NUM_CH-1:0][FILL_W-1:0]                       fill_q, fill_d;
  logic [NUM_CH-1:0]                                   phase_q, phase_d;
  logic [K-1:0][COEF_W-1:0]                            coef_q, coef_d;
  logic [CA_W-1:0]                                     k_q, k_d;
  logic [CH_W-1:0]                                     ch_q, ch_d;
  logic signed [ACC_W-1:0]                             acc_q, acc_d;
  logic                                                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]                                   m_data_q, m_data_d;
  logic [CH_W-1:0]                                     m_chan_q, m_chan_d;
  logic                                                sat_q, sat_d;
  logic                                                rdy_q, rdy_d;

  logic [IDX_W-1:0]         idx_a, idx_b;
  logic [DATA_W-1:0]        x_a, x_b, x_c;
  logic signed [PRE_W-1:0]  pre;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, ctr_ext, rnd, shr, max_v, min_v;
  logic [DATA_W-1:0]        r_sat;
  logic                     sat_now;

  assign s_ready  = rdy_q && (state_q == StIdle) && !m_valid_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_chan   = m_chan_q;
  assign sat_flag = sat_q;

  // Shared datapath: symmetric pre-add, one multiply, fixed 0.5 centre tap, round and clamp.
  always_comb begin
    idx_a    = IDX_W'({k_q, 1'b0});
    idx_b    = IDX_W'(NUM_TAPS - 1) - idx_a;
    x_a      = buf_q[ch_q][idx_a];
    x_b      = buf_q[ch_q][idx_b];
    x_c      = buf_q[ch_q][CENTER];
    pre      = $signed({x_a[DATA_W-1], x_a}) + $signed({x_b[DATA_W-1], x_b});
    prod     = pre * $signed(coef_q[k_q]);
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    ctr_ext  = {{(ACC_W - DATA_W){x_c[DATA_W-1]}}, x_c} <<< (COEF_FRAC - 1);
    rnd      = acc_q + (ACC_W'(1) << (COEF_FRAC - 1));
    shr      = rnd >>> COEF_FRAC;
    max_v    = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    min_v    = ~max_v;
    sat_now  = (shr > max_v) || (shr < min_v);
    if (shr > max_v) begin
      r_sat = max_v[DATA_W-1:0];
    end else if (shr < min_v) begin
      r_sat = min_v[DATA_W-1:0];
    end else begin
      r_sat = shr[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    phase_d   = phase_q;
    coef_d    = coef_q;
    k_d       = k_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    sat_d     = sat_q;
    rdy_d     = 1'b1;

    if (clear_sat) sat_d = 1'b0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (coef_we && (32'(coef_addr) < K)) coef_d[coef_addr] = coef_wdata;
        // Out-of-range channels are consumed without touching any state.
        if (s_valid && s_ready && (32'(s_chan) < NUM_CH)) begin
          if (bypass) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_chan_d  = s_chan;
          end else begin
            buf_d[s_chan]   = {buf_q[s_chan][NUM_TAPS-2:0], s_data};
            phase_d[s_chan] = ~phase_q[s_chan];
            if (fill_q[s_chan] != FILL_W'(NUM_TAPS)) fill_d[s_chan] = fill_q[s_chan] + 1'b1;
            if (!phase_q[s_chan] && (fill_d[s_chan] == FILL_W'(NUM_TAPS))) begin
              state_d = StMac;
              k_d     = '0;
              ch_d    = s_chan;
              acc_d   = '0;
            end
          end
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        if (k_q == CA_W'(K - 1)) begin
          state_d = StCenter;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StCenter: begin
        acc_d   = acc_q + ctr_ext;
        state_d = StRound;
      end
      StRound: begin
        m_valid_d = 1'b1;
        m_data_d  = r_sat;
        m_chan_d  = ch_q;
        if (sat_now) sat_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      buf_q     <= '0;
      fill_q    <= '0;
      phase_q   <= '0;
      coef_q    <= CoefRst;
      k_q       <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
      sat_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      phase_q   <= phase_d;
      coef_q    <= coef_d;
      k_q       <= k_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
      sat_q     <= sat_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_hb_decim_tdm.sv
// Directed bench for hb_decim_tdm: direct-form reference model feeds a scoreboard of expected
// outputs, plus fixed checks on impulse taps, latency, saturation, bypass and reset behaviour.
module tb_hb_decim_tdm;

  localparam int Taps = 27;
  localparam int Kc   = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bypass;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_chan;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_chan;
  logic        sat_flag;
  logic        clear_sat;

  always #5 clk = ~clk;

  hb_decim_tdm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bypass     (bypass),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_chan     (s_chan),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .sat_flag   (sat_flag),
    .clear_sat  (clear_sat)
  );

  typedef struct packed {
    logic        chan;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   nz_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   out_cnt = 0;

  int hist[2][Taps];
  int fill_m[2];
  bit phase_m[2];
  int coef_m[Kc];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      fill_m[c]  = 0;
      phase_m[c] = 1'b0;
      for (int j = 0; j < Taps; j++) hist[c][j] = 0;
    end
    coef_m = '{3, -25, 117, -394, 1078, -2753, 10165};
  endtask

  // Direct-form reference: full 27-tap impulse response convolved with the history.
  task automatic model_accept(input int ch, input int d, input bit byp);
    int     h[Taps];
    longint acc;
    longint r;
    exp_t   e;
    if (byp) begin
      e.chan = ch[0];
      e.data = d[15:0];
      exp_q.push_back(e);
      return;
    end
    for (int j = Taps - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
    hist[ch][0] = d;
    phase_m[ch] = !phase_m[ch];
    if (fill_m[ch] < Taps) fill_m[ch]++;
    if (phase_m[ch] && fill_m[ch] == Taps) begin
      for (int j = 0; j < Taps; j++) h[j] = 0;
      for (int k = 0; k < Kc; k++) begin
        h[2*k]          = coef_m[k];
        h[Taps-1-2*k]   = coef_m[k];
      end
      h[(Taps-1)/2] = 16384;
      acc = 0;
      for (int j = 0; j < Taps; j++) acc += longint'(h[j]) * longint'(hist[ch][j]);
      r = (acc + 64'sd16384) >>> 15;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      e.chan = ch[0];
      e.data = r[15:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int ch, input int d);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_chan  = ch[0];
    s_data  = d[15:0];
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("send_ready", s_ready, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    model_accept(ch, d, bypass);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid || !s_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic impulse_p1(input string tag);
    int ref_nz[14] = '{2, -12, 59, -197, 539, -1376, 5083, 5083, -1376, 539, -197, 59, -12, 2};
    int n = 0;
    nz_q.delete();
    for (int i = 0; i < 28; i++) send(0, 0);
    send(0, 16384);
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    for (int i = 0; i < 26; i++) send(0, 0);
    drain();
    chk({tag, "_nz_cnt"}, nz_q.size(), 14);
    for (int i = 0; i < 14 && i < nz_q.size(); i++)
      chk($sformatf("%s_nz%0d", tag, i), nz_q[i], ref_nz[i]);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && m_valid && m_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", $signed(m_data), $signed(e.data));
        chk("m_chan", m_chan, e.chan);
      end
      if (m_data != 16'd0) nz_q.push_back(int'($signed(m_data)));
    end
  end

  initial begin
    int n;
    int seen;
    reset_n    = 1'b0;
    bypass     = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_chan     = 1'b0;
    m_ready    = 1'b1;
    clear_sat  = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_sat", sat_flag, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);

    // Impulse landing on phase 1
    impulse_p1("imp1");

    // Impulse landing on phase 0: only the centre tap contributes
    do_reset();
    nz_q.delete();
    for (int i = 0; i < 27; i++) send(0, 0);
    send(0, 16384);
    for (int i = 0; i < 27; i++) send(0, 0);
    drain();
    chk("imp0_nz_cnt", nz_q.size(), 1);
    if (nz_q.size() > 0) chk("imp0_value", nz_q[0], 8192);

    // Interleaved DC with a coefficient write dropped while busy
    do_reset();
    out_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      send(0, 1000);
      if (i == 28) begin
        coef_addr  = 3'd0;
        coef_wdata = 16'd20000;
        coef_we    = 1'b1;
        @(posedge clk);
        #1;
        coef_we    = 1'b0;
      end
      send(1, 1000);
    end
    drain();
    chk("dc_out_cnt", out_cnt, 14);

    // Bypass must not disturb channel history or phase
    bypass = 1'b1;
    send(0, 16'h1234);
    chk("byp_valid", m_valid, 1);
    chk("byp_data", m_data, 16'h1234);
    chk("byp_chan", m_chan, 0);
    bypass = 1'b0;
    drain();

    // Backpressure
    m_ready = 1'b0;
    send(0, 1000);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 1000);
    chk("bp_s_ready", s_ready, 0);
    m_ready = 1'b1;
    drain();
    for (int i = 0; i < 4; i++) begin
      send(1, 1000);
      send(0, 1000);
    end
    drain();

    // Saturation with a coefficient written in IDLE
    do_reset();
    @(negedge clk);
    coef_addr  = 3'd6;
    coef_wdata = 16'h7fff;
    coef_we    = 1'b1;
    @(negedge clk);
    coef_we    = 1'b0;
    coef_m[6]  = 32767;
    for (int i = 0; i < 27; i++) send(0, 32767);
    drain();
    chk("sat_set", sat_flag, 1);
    clear_sat = 1'b1;
    @(negedge clk);
    clear_sat = 1'b0;
    chk("sat_clear", sat_flag, 0);
    send(0, 32767);
    send(0, 32767);
    repeat (8) @(posedge clk);
    #1;
    clear_sat = 1'b1;
    @(posedge clk);
    #1;
    clear_sat = 1'b0;
    chk("sat_coinc_valid", m_valid, 1);
    chk("sat_coinc_flag", sat_flag, 1);
    drain();

    // Reset while the MAC is running
    send(0, 500);
    send(0, 500);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    chk("rst_mac_no_valid", seen, 0);
    chk("rst_mac_data", m_data, 0);
    chk("rst_mac_sat", sat_flag, 0);

    // Defaults and zeroed history are back
    impulse_p1("imp2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
